grf_wb_arbiter: RTL and testbench
=================================

// Module: grf_wb_arbiter
// PURPOSE
// - Write-side front end of the GRF: the single owner of the GRF write port (RegWrite/A3/WD/PC).
// - Merges the in-order W-stage writeback with results from multi-cycle units (MDU, later CP0)
//   through a small in-order deferred-write queue.
// - Exports per-read-port "pending" flags so the D-stage hazard unit stalls on queued writes.
// PARAMETERS
// - DEPTH   2   deferred-write queue entries (power of two, 2..8)
// - DATA_W  32  register data width
// - ADDR_W  5   register index width
// PORTS
// - clk        in   1       system clock; all state updates on posedge
// - reset      in   1       synchronous, active-high; sampled on posedge clk only
// - pipe_we    in   1       W stage requests a register write this cycle
// - pipe_a3    in   ADDR_W  W-stage destination register
// - pipe_wd    in   DATA_W  W-stage write data
// - pipe_pc    in   32      PC of the W-stage instruction (trace)
// - aux_valid  in   1       multi-cycle unit offers a result
// - aux_ready  out  1       queue accepts the result; transfer when aux_valid & aux_ready
// - aux_a3     in   ADDR_W  aux destination register
// - aux_wd     in   DATA_W  aux result data
// - aux_pc     in   32      PC of the originating instruction
// - grf_we     out  1       drives GRF RegWrite
// - grf_a3     out  ADDR_W  drives GRF A3
// - grf_wd     out  DATA_W  drives GRF WD
// - grf_pc     out  32      drives GRF PC (trace display)
// - q_a1/q_a2  in   ADDR_W  D-stage read addresses (GRF A1/A2)
// - pend1/2    out  1       a live queued write targets q_a1/q_a2
// BEHAVIOUR
// - Reset, in the cycle reset is high: queue emptied, all entry-live bits cleared.
//   aux_ready=0, grf_we=0, pend1=pend2=0, grf_a3/wd/pc=0.
//   Reset asserted mid-drain discards all queued writes; none reach the GRF.
// - Write-port priority: pipe write beats queue drain. The W stage never stalls.
// - Pipe write: grf_we=1 combinationally, zero latency; a3/wd/pc passed straight through.
// - $0: a pipe write with a3=0 gives grf_we=0 and grf_a3=0. An aux transfer with a3=0
//   completes the handshake but is not enqueued.
// - aux_ready = !full (registered count, no dependence on same-cycle pop).
//   Push and pop in the same cycle: count unchanged.
// - Drain: no effective pipe write and head entry live -> grf_we=1 with head a3/wd/pc; pop at posedge.
// - Squash (WAW): pipe write to r!=0 clears the live bit of every queued entry with a3==r at the
//   same posedge. A same-cycle aux transfer to r is accepted and dropped.
//   Queued results are older than any concurrent W-stage write.
// - Dead head: a non-live head is popped in any cycle, including pipe-write cycles, with no
//   GRF write. Each pop takes one cycle.
// - pend1 = (q_a1!=0) & OR over entries of (live & a3==q_a1); same rule for pend2.
//   Purely combinational from registered state; does not include same-cycle aux input.
// - Pointers are log2(DEPTH) bits and wrap modulo DEPTH. count is log2(DEPTH)+1 bits.
//   full = count==DEPTH; empty = count==0.
// - Queue drains strictly in accept order; no reordering except squash.
// - Latency: aux accept to GRF write is >=1 cycle (empty queue, no pipe write: next cycle).
// STRUCTURE
// - Shared header mips_defs.vh: REG_ZERO=5'd0, DATA_W/ADDR_W defaults.
//   The same constants are used by GRF and the hazard unit.
// - Sub-module wb_queue: DEPTH-entry circular buffer {live,a3,wd,pc} with push/pop/count, a
//   per-entry squash-by-address input and per-entry live/a3 taps for the pend compare.
// - Top level holds the write-port mux, $0 filtering and the pend comparators.
// TESTING
// - Reset: hold reset 2 cycles with aux_valid=1 -> aux_ready=0, grf_we=0, pend1=0; no enqueue.
// - Pass-through: pipe_we=1, a3=8, wd=32'h1234 -> same cycle grf_we=1, grf_a3=8,
//   grf_wd=32'h1234; aux_ready stays 1.
// - Deferral and priority: aux a3=9, wd=32'hAAAA with pipe writes to $10 for 3 cycles.
//   Expect pend for q_a1=9 held high and $9 written in the first free cycle.
//   pend drops on the following cycle.
// - Full: DEPTH=2, push $3 and $4 under continuous pipe writes -> aux_ready=0.
//   A third aux stays stalled until one pop; queue drains in order $3 then $4.
// - WAW squash: queue $5=32'h1, then pipe write $5=32'h2 -> $5 stays 32'h2 and pend for $5 clears.
//   The dead entry is popped with no write.
// - $0 and mid-drain reset: aux a3=0 -> handshake completes, queue empty, pend=0.
//   Queue two entries, pulse reset -> no grf_we after reset deasserts.

Source files
------------

// File: rtl/grf_wb_arbiter_pkg.sv
// Shared constants and types for the GRF write-side arbiter. The GRF and the
// hazard unit use the same register-index constants.
package grf_wb_arbiter_pkg;

    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned ADDR_W_DEF = 5;
    localparam int unsigned DEPTH_DEF  = 2;
    localparam logic [4:0]  REG_ZERO   = 5'd0;

    // Which source owns the GRF write port this cycle
    typedef enum logic [1:0] {
        WSRC_NONE  = 2'd0,
        WSRC_PIPE  = 2'd1,
        WSRC_QUEUE = 2'd2
    } wsrc_e;

endpackage : grf_wb_arbiter_pkg

// File: rtl/grf_wb_arbiter_wb_queue.sv
// In-order deferred-write queue: circular buffer of {live, a3, wd, pc} with
// squash-by-address and per-entry taps for the pending-read compare.
module grf_wb_arbiter_wb_queue #(
    parameter int unsigned DEPTH  = 2,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5,
    localparam int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          push,
    input  logic [ADDR_W-1:0]             push_a3,
    input  logic [DATA_W-1:0]             push_wd,
    input  logic [31:0]                   push_pc,
    input  logic                          pop,
    input  logic                          squash_en,
    input  logic [ADDR_W-1:0]             squash_a3,
    output logic [PTR_W:0]                count,
    output logic                          head_live,
    output logic [ADDR_W-1:0]             head_a3,
    output logic [DATA_W-1:0]             head_wd,
    output logic [31:0]                   head_pc,
    output logic [DEPTH-1:0]              live_tap,
    output logic [DEPTH-1:0][ADDR_W-1:0]  a3_tap
);

    logic [DEPTH-1:0]  live_r;
    logic [ADDR_W-1:0] a3_r [DEPTH];
    logic [DATA_W-1:0] wd_r [DEPTH];
    logic [31:0]       pc_r [DEPTH];
    logic [PTR_W-1:0]  head_r;
    logic [PTR_W-1:0]  tail_r;
    logic [PTR_W:0]    count_r;

    logic [DEPTH-1:0]  live_next_s;
    logic [PTR_W:0]    count_next_s;

    // Live bits outside the occupied window stay cleared, so pend can OR over all slots
    always_comb begin
        live_next_s = live_r;
        for (int i = 0; i < DEPTH; i++) begin
            if (push && (tail_r == PTR_W'(i))) begin
                live_next_s[i] = 1'b1;
            end else if ((pop && (head_r == PTR_W'(i))) ||
                         (squash_en && (a3_r[i] == squash_a3))) begin
                live_next_s[i] = 1'b0;
            end else begin
                live_next_s[i] = live_r[i];
            end
        end
    end

    // Occupancy update; simultaneous push and pop leaves it unchanged
    always_comb begin
        count_next_s = count_r;
        case ({push, pop})
            2'b10:   count_next_s = count_r + (PTR_W+1)'(1);
            2'b01:   count_next_s = count_r - (PTR_W+1)'(1);
            default: count_next_s = count_r;
        endcase
    end

    // Queue state register
    always_ff @(posedge clk) begin
        if (reset) begin
            head_r  <= '0;
            tail_r  <= '0;
            count_r <= '0;
            live_r  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                a3_r[i] <= '0;
                wd_r[i] <= '0;
                pc_r[i] <= 32'd0;
            end
        end else begin
            live_r  <= live_next_s;
            count_r <= count_next_s;
            if (push) begin
                a3_r[tail_r] <= push_a3;
                wd_r[tail_r] <= push_wd;
                pc_r[tail_r] <= push_pc;
                tail_r       <= tail_r + PTR_W'(1);
            end
            if (pop) begin
                head_r <= head_r + PTR_W'(1);
            end
        end
    end

    // Head view and per-entry taps
    always_comb begin
        count     = count_r;
        head_live = live_r[head_r];
        head_a3   = a3_r[head_r];
        head_wd   = wd_r[head_r];
        head_pc   = pc_r[head_r];
        live_tap  = live_r;
        for (int i = 0; i < DEPTH; i++) begin
            a3_tap[i] = a3_r[i];
        end
    end

endmodule : grf_wb_arbiter_wb_queue

// File: rtl/grf_wb_arbiter.sv
// Sole owner of the GRF write port: W-stage writes pass straight through,
// multi-cycle results wait in an in-order queue and drain in free cycles.
module grf_wb_arbiter
    import grf_wb_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH  = DEPTH_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pipe_we,
    input  logic [ADDR_W-1:0] pipe_a3,
    input  logic [DATA_W-1:0] pipe_wd,
    input  logic [31:0]       pipe_pc,
    input  logic              aux_valid,
    output logic              aux_ready,
    input  logic [ADDR_W-1:0] aux_a3,
    input  logic [DATA_W-1:0] aux_wd,
    input  logic [31:0]       aux_pc,
    output logic              grf_we,
    output logic [ADDR_W-1:0] grf_a3,
    output logic [DATA_W-1:0] grf_wd,
    output logic [31:0]       grf_pc,
    input  logic [ADDR_W-1:0] q_a1,
    input  logic [ADDR_W-1:0] q_a2,
    output logic              pend1,
    output logic              pend2
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(REG_ZERO);

    logic [PTR_W:0]               q_count_s;
    logic                         q_full_s;
    logic                         q_empty_s;
    logic                         head_live_s;
    logic [ADDR_W-1:0]            head_a3_s;
    logic [DATA_W-1:0]            head_wd_s;
    logic [31:0]                  head_pc_s;
    logic [DEPTH-1:0]             live_tap_s;
    logic [DEPTH-1:0][ADDR_W-1:0] a3_tap_s;

    logic  pipe_eff_s;
    logic  push_s;
    logic  pop_s;
    wsrc_e wsrc_s;

    assign q_full_s   = (q_count_s == (PTR_W+1)'(DEPTH));
    assign q_empty_s  = (q_count_s == (PTR_W+1)'(0));
    assign pipe_eff_s = pipe_we && (pipe_a3 != ZERO_A);
    assign aux_ready  = !reset && !q_full_s;

    // A $0 result or one overwritten by the concurrent W-stage write is accepted but never stored
    assign push_s = aux_valid && aux_ready && (aux_a3 != ZERO_A) &&
                    !(pipe_eff_s && (aux_a3 == pipe_a3));

    // Dead heads leave in any cycle; live heads only when the port is free
    assign pop_s = !q_empty_s && (!head_live_s || !pipe_eff_s);

    grf_wb_arbiter_wb_queue #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_wb_queue (
        .clk       (clk),
        .reset     (reset),
        .push      (push_s),
        .push_a3   (aux_a3),
        .push_wd   (aux_wd),
        .push_pc   (aux_pc),
        .pop       (pop_s),
        .squash_en (pipe_eff_s),
        .squash_a3 (pipe_a3),
        .count     (q_count_s),
        .head_live (head_live_s),
        .head_a3   (head_a3_s),
        .head_wd   (head_wd_s),
        .head_pc   (head_pc_s),
        .live_tap  (live_tap_s),
        .a3_tap    (a3_tap_s)
    );

    // Write-port owner: pipe beats queue
    always_comb begin
        wsrc_s = WSRC_NONE;
        if (reset) begin
            wsrc_s = WSRC_NONE;
        end else if (pipe_eff_s) begin
            wsrc_s = WSRC_PIPE;
        end else if (!q_empty_s && head_live_s) begin
            wsrc_s = WSRC_QUEUE;
        end else begin
            wsrc_s = WSRC_NONE;
        end
    end

    // GRF write-port mux
    always_comb begin
        grf_we = 1'b0;
        grf_a3 = '0;
        grf_wd = '0;
        grf_pc = 32'd0;
        case (wsrc_s)
            WSRC_PIPE: begin
                grf_we = 1'b1;
                grf_a3 = pipe_a3;
                grf_wd = pipe_wd;
                grf_pc = pipe_pc;
            end
            WSRC_QUEUE: begin
                grf_we = 1'b1;
                grf_a3 = head_a3_s;
                grf_wd = head_wd_s;
                grf_pc = head_pc_s;
            end
            default: begin
                grf_we = 1'b0;
                grf_a3 = '0;
                grf_wd = '0;
                grf_pc = 32'd0;
            end
        endcase
    end

    // Pending-read flags from registered queue state only
    always_comb begin
        pend1 = 1'b0;
        pend2 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (live_tap_s[i] && (a3_tap_s[i] == q_a1)) begin
                pend1 = 1'b1;
            end else begin
                pend1 = pend1;
            end
            if (live_tap_s[i] && (a3_tap_s[i] == q_a2)) begin
                pend2 = 1'b1;
            end else begin
                pend2 = pend2;
            end
        end
        if (reset) begin
            pend1 = 1'b0;
            pend2 = 1'b0;
        end else begin
            pend1 = pend1 && (q_a1 != ZERO_A);
            pend2 = pend2 && (q_a2 != ZERO_A);
        end
    end

endmodule : grf_wb_arbiter

// File: tb/tb_grf_wb_arbiter.sv
// Directed and randomized bench for grf_wb_arbiter against a queue-level
// reference model of the write-port arbitration rules.
module tb_grf_wb_arbiter;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        pipe_we;
    logic [4:0]  pipe_a3;
    logic [31:0] pipe_wd;
    logic [31:0] pipe_pc;
    logic        aux_valid;
    logic        aux_ready;
    logic [4:0]  aux_a3;
    logic [31:0] aux_wd;
    logic [31:0] aux_pc;
    logic        grf_we;
    logic [4:0]  grf_a3;
    logic [31:0] grf_wd;
    logic [31:0] grf_pc;
    logic [4:0]  q_a1;
    logic [4:0]  q_a2;
    logic        pend1;
    logic        pend2;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        bit          live;
        logic [4:0]  a3;
        logic [31:0] wd;
        logic [31:0] pc;
    } ment_t;

    ment_t mq[$];

    grf_wb_arbiter #(.DEPTH(DEPTH), .DATA_W(32), .ADDR_W(5)) dut (
        .clk       (clk),
        .reset     (reset),
        .pipe_we   (pipe_we),
        .pipe_a3   (pipe_a3),
        .pipe_wd   (pipe_wd),
        .pipe_pc   (pipe_pc),
        .aux_valid (aux_valid),
        .aux_ready (aux_ready),
        .aux_a3    (aux_a3),
        .aux_wd    (aux_wd),
        .aux_pc    (aux_pc),
        .grf_we    (grf_we),
        .grf_a3    (grf_a3),
        .grf_wd    (grf_wd),
        .grf_pc    (grf_pc),
        .q_a1      (q_a1),
        .q_a2      (q_a2),
        .pend1     (pend1),
        .pend2     (pend2)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    // Expected outputs from the current model queue and inputs
    task automatic model_check();
        bit          pe;
        logic        e_we, e_rdy, e_p1, e_p2;
        logic [4:0]  e_a3;
        logic [31:0] e_wd, e_pc;
        e_we = 1'b0; e_rdy = 1'b0; e_p1 = 1'b0; e_p2 = 1'b0;
        e_a3 = 5'd0; e_wd = 32'd0; e_pc = 32'd0;
        if (!reset) begin
            pe    = pipe_we && (pipe_a3 != 5'd0);
            e_rdy = (mq.size() < DEPTH);
            if (pe) begin
                e_we = 1'b1; e_a3 = pipe_a3; e_wd = pipe_wd; e_pc = pipe_pc;
            end else if (mq.size() > 0 && mq[0].live) begin
                e_we = 1'b1; e_a3 = mq[0].a3; e_wd = mq[0].wd; e_pc = mq[0].pc;
            end
            foreach (mq[i]) begin
                if (mq[i].live && mq[i].a3 == q_a1 && q_a1 != 5'd0) e_p1 = 1'b1;
                if (mq[i].live && mq[i].a3 == q_a2 && q_a2 != 5'd0) e_p2 = 1'b1;
            end
        end
        check_eq("aux_ready", aux_ready, e_rdy);
        check_eq("grf_we", grf_we, e_we);
        check_eq("grf_a3", grf_a3, e_a3);
        check_eq("grf_wd", grf_wd, e_wd);
        check_eq("grf_pc", grf_pc, e_pc);
        check_eq("pend1", pend1, e_p1);
        check_eq("pend2", pend2, e_p2);
    endtask

    // Advance the model by one clock edge using the inputs seen at that edge
    task automatic model_step();
        bit pe;
        bit was_full;
        ment_t e;
        if (reset) begin
            mq.delete();
        end else begin
            pe       = pipe_we && (pipe_a3 != 5'd0);
            was_full = (mq.size() == DEPTH);
            if (mq.size() > 0 && (!mq[0].live || !pe)) void'(mq.pop_front());
            if (pe) foreach (mq[i]) if (mq[i].a3 == pipe_a3) mq[i].live = 1'b0;
            if (aux_valid && !was_full && aux_a3 != 5'd0 && !(pe && aux_a3 == pipe_a3)) begin
                e.live = 1'b1; e.a3 = aux_a3; e.wd = aux_wd; e.pc = aux_pc;
                mq.push_back(e);
            end
        end
    endtask

    task automatic sample();
        @(negedge clk);
        model_check();
    endtask

    task automatic advance();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic cycle();
        sample();
        advance();
    endtask

    task automatic set_pipe(input logic we, input logic [4:0] a3, input logic [31:0] wd);
        pipe_we = we; pipe_a3 = a3; pipe_wd = wd; pipe_pc = 32'h0040_0000 + {wd[15:0], 2'b00};
    endtask

    task automatic set_aux(input logic v, input logic [4:0] a3, input logic [31:0] wd);
        aux_valid = v; aux_a3 = a3; aux_wd = wd; aux_pc = 32'h0050_0000 + {wd[15:0], 2'b00};
    endtask

    initial begin
        reset = 1'b1;
        set_pipe(1'b0, 5'd0, 32'd0);
        set_aux(1'b1, 5'd7, 32'h77);
        q_a1 = 5'd7; q_a2 = 5'd0;

        // Reset held two cycles with an aux offer
        repeat (2) begin
            sample();
            check_eq("rst_ready", aux_ready, 32'd0);
            check_eq("rst_we", grf_we, 32'd0);
            advance();
        end
        reset = 1'b0;
        set_aux(1'b0, 5'd0, 32'd0);

        // Pass-through
        set_pipe(1'b1, 5'd8, 32'h1234);
        sample();
        check_eq("pt_we", grf_we, 32'd1);
        check_eq("pt_a3", grf_a3, 32'd8);
        check_eq("pt_wd", grf_wd, 32'h1234);
        check_eq("pt_ready", aux_ready, 32'd1);
        advance();

        // Deferral behind three pipe writes
        q_a1 = 5'd9;
        set_pipe(1'b1, 5'd10, 32'h10);
        set_aux(1'b1, 5'd9, 32'hAAAA);
        cycle();
        set_aux(1'b0, 5'd0, 32'd0);
        repeat (2) begin
            sample();
            check_eq("def_pend", pend1, 32'd1);
            advance();
        end
        set_pipe(1'b0, 5'd0, 32'd0);
        sample();
        check_eq("def_a3", grf_a3, 32'd9);
        check_eq("def_wd", grf_wd, 32'hAAAA);
        advance();
        sample();
        check_eq("def_pend_drop", pend1, 32'd0);
        advance();

        // Full queue stalls a third result; drain order $3, $4, $6
        set_pipe(1'b1, 5'd10, 32'h11);
        set_aux(1'b1, 5'd3, 32'h3333);
        cycle();
        set_aux(1'b1, 5'd4, 32'h4444);
        cycle();
        set_aux(1'b1, 5'd6, 32'h6666);
        sample();
        check_eq("full_ready", aux_ready, 32'd0);
        advance();
        set_pipe(1'b0, 5'd0, 32'd0);
        sample();
        check_eq("drain1_a3", grf_a3, 32'd3);
        advance();
        sample();
        check_eq("drain2_a3", grf_a3, 32'd4);
        advance();
        set_aux(1'b0, 5'd0, 32'd0);
        repeat (2) cycle();

        // WAW squash of a queued $5
        q_a1 = 5'd5;
        set_aux(1'b1, 5'd5, 32'h1);
        cycle();
        set_aux(1'b0, 5'd0, 32'd0);
        set_pipe(1'b1, 5'd5, 32'h2);
        sample();
        check_eq("waw_wd", grf_wd, 32'h2);
        advance();
        set_pipe(1'b0, 5'd0, 32'd0);
        sample();
        check_eq("waw_dead_we", grf_we, 32'd0);
        check_eq("waw_pend", pend1, 32'd0);
        advance();
        cycle();

        // $0 aux result is accepted but never queued
        q_a1 = 5'd0;
        set_aux(1'b1, 5'd0, 32'h55);
        sample();
        check_eq("z_ready", aux_ready, 32'd1);
        advance();
        set_aux(1'b0, 5'd0, 32'd0);
        sample();
        check_eq("z_we", grf_we, 32'd0);
        advance();

        // Reset while two entries are queued discards them
        q_a1 = 5'd11; q_a2 = 5'd12;
        set_pipe(1'b1, 5'd10, 32'h12);
        set_aux(1'b1, 5'd11, 32'hB);
        cycle();
        set_aux(1'b1, 5'd12, 32'hC);
        cycle();
        set_aux(1'b0, 5'd0, 32'd0);
        set_pipe(1'b0, 5'd0, 32'd0);
        reset = 1'b1;
        sample();
        check_eq("mrst_we", grf_we, 32'd0);
        advance();
        reset = 1'b0;
        repeat (3) begin
            sample();
            check_eq("post_rst_we", grf_we, 32'd0);
            check_eq("post_rst_pend", pend1, 32'd0);
            advance();
        end

        // Randomized traffic over a small register window to force collisions
        for (int n = 0; n < 600; n++) begin
            reset = ($urandom_range(0, 59) == 0);
            set_pipe(($urandom_range(0, 1) == 1), 5'($urandom_range(0, 7)), $urandom);
            set_aux(($urandom_range(0, 2) != 0), 5'($urandom_range(0, 7)), $urandom);
            q_a1 = 5'($urandom_range(0, 7));
            q_a2 = 5'($urandom_range(0, 7));
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_grf_wb_arbiter
